// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_pkg                                                               |
// | Shared framebuffer geometry, pixel entry type and writer FSM states. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fb_pkg;
   localparam int H_RES    = 160;
   localparam int V_RES    = 120;
   localparam int FB_WORDS = 19200;
   localparam int ADDR_W   = 15;
   localparam int COLOUR_W = 3;

   typedef logic [COLOUR_W-1:0] colour_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      colour_t           colour;
   } pix_entry_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } fbw_state_t;
endpackage
`default_nettype wire

// File: rtl/fb_pix_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_pix_fifo                                                          |
// | Synchronous FIFO of pixel entries with push, pop and flush.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fb_pix_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  pix_entry_t               i_wr_data,
   output pix_entry_t               o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int c_PTR_W = $clog2(DEPTH);

   pix_entry_t                r_mem [DEPTH];
   logic [c_PTR_W-1:0]        r_wr_ptr;
   logic [c_PTR_W-1:0]        r_rd_ptr;
   logic [c_PTR_W:0]          r_count;

   // Flush wins over any same-cycle push or pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_pixel_writer                                                      |
// | Buffers drawn pixels and commits them (or a full-screen clear) to    |
// | the framebuffer through an arbitrated write slot.                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int H_RES      = 160,
   parameter int V_RES      = 120
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pix_wr,
   input  logic [8:0]          pix_x,
   input  logic [8:0]          pix_y,
   input  logic [2:0]          pix_colour,
   output logic                pix_ready,
   input  logic                clear_req,
   input  logic [2:0]          clear_colour,
   input  logic                mem_grant,
   output logic                mem_we,
   output logic [14:0]         mem_addr,
   output logic [2:0]          mem_data,
   output logic                busy,
   output logic [7:0]          drop_count
);
   fbw_state_t                r_state;
   logic [ADDR_W-1:0]         r_sweep;
   colour_t                   r_clear_colour;
   logic                      r_mem_we;
   logic [ADDR_W-1:0]         r_mem_addr;
   colour_t                   r_mem_data;
   logic [7:0]                r_drop_count;

   logic                      w_idle;
   logic                      w_ready;
   logic                      w_in_range;
   logic                      w_clear_start;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_drop;
   pix_entry_t                w_new_entry;
   pix_entry_t                w_head;
   logic [$clog2(FIFO_DEPTH):0] w_count;
   logic                      w_full;
   logic                      w_empty;

   assign w_idle        = (r_state == IDLE);
   assign w_ready       = w_idle && !w_full;
   assign w_in_range    = (int'(pix_x) < H_RES) && (int'(pix_y) < V_RES);
   assign w_clear_start = w_idle && clear_req;
   assign w_push        = pix_wr && w_ready && w_in_range && !w_clear_start;
   assign w_drop        = pix_wr && !w_push;
   // A clear request discards the queue, so nothing is popped that cycle
   assign w_pop         = w_idle && mem_grant && !w_empty && !w_clear_start;

   // y*160 as (y<<7)+(y<<5); only in-range coordinates ever reach the FIFO
   assign w_new_entry.addr   = ADDR_W'({pix_y, 7'b0}) + ADDR_W'({pix_y, 5'b0})
                               + ADDR_W'(pix_x);
   assign w_new_entry.colour = pix_colour;

   fb_pix_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_flush   (w_clear_start),
      .i_wr_data (w_new_entry),
      .o_rd_data (w_head),
      .o_count   (w_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_sweep        <= '0;
         r_clear_colour <= '0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_data     <= '0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (clear_req) begin
                  r_clear_colour <= clear_colour;
                  r_sweep        <= '0;
                  r_state        <= CLEAR;
               end else if (w_pop) begin
                  r_mem_we   <= 1'b1;
                  r_mem_addr <= w_head.addr;
                  r_mem_data <= w_head.colour;
               end
            end
            CLEAR: begin
               if (mem_grant) begin
                  r_mem_we   <= 1'b1;
                  r_mem_addr <= r_sweep;
                  r_mem_data <= r_clear_colour;
                  r_sweep    <= r_sweep + 1'b1;
                  if (r_sweep == ADDR_W'(FB_WORDS - 1)) r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != 8'hFF)) begin
         r_drop_count <= r_drop_count + 8'd1;
      end
   end

   assign pix_ready  = w_ready;
   assign busy       = !w_idle || (w_count != '0);
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_data   = r_mem_data;
   assign drop_count = r_drop_count;
endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fb_pixel_writer                                                   |
// | Scoreboard bench: a queue-level framebuffer-writer model predicts    |
// | every RAM write; a monitor compares writes as they appear.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fb_pixel_writer;
   logic        clk = 1'b0;
   logic        reset;
   logic        pix_wr;
   logic [8:0]  pix_x;
   logic [8:0]  pix_y;
   logic [2:0]  pix_colour;
   logic        pix_ready;
   logic        clear_req;
   logic [2:0]  clear_colour;
   logic        mem_grant;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [2:0]  mem_data;
   logic        busy;
   logic [7:0]  drop_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int  mq_addr[$];
   int  mq_col[$];
   int  exp_addr[$];
   int  exp_col[$];
   bit  m_clear = 0;
   int  m_sweep = 0;
   int  m_ccol  = 0;
   int  m_drop  = 0;

   fb_pixel_writer #(
      .FIFO_DEPTH (4),
      .H_RES      (160),
      .V_RES      (120)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pix_wr       (pix_wr),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_colour   (pix_colour),
      .pix_ready    (pix_ready),
      .clear_req    (clear_req),
      .clear_colour (clear_colour),
      .mem_grant    (mem_grant),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .busy         (busy),
      .drop_count   (drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq_addr.delete(); mq_col.delete();
      exp_addr.delete(); exp_col.delete();
      m_clear = 0; m_sweep = 0; m_ccol = 0; m_drop = 0;
   endtask

   // One clock cycle: check visible status, drive inputs, advance the model
   task automatic cycle(input bit wr, input int x, input int y, input int c,
                        input bit clr, input int cc, input bit g);
      bit rdy, clr_now, accept;
      @(negedge clk);
      chk("pix_ready", pix_ready, (!m_clear && mq_addr.size() < 4) ? 1 : 0);
      chk("busy", busy, (m_clear || mq_addr.size() > 0) ? 1 : 0);
      chk("drop_count", drop_count, m_drop);
      pix_wr = wr; pix_x = 9'(x); pix_y = 9'(y); pix_colour = 3'(c);
      clear_req = clr; clear_colour = 3'(cc); mem_grant = g;

      rdy     = !m_clear && mq_addr.size() < 4;
      clr_now = clr && !m_clear;
      if (!m_clear && g && mq_addr.size() > 0 && !clr_now) begin
         exp_addr.push_back(mq_addr.pop_front());
         exp_col.push_back(mq_col.pop_front());
      end
      if (m_clear && g) begin
         exp_addr.push_back(m_sweep);
         exp_col.push_back(m_ccol);
         m_sweep++;
         if (m_sweep == 160 * 120) m_clear = 0;
      end
      accept = wr && rdy && x < 160 && y < 120 && !clr_now;
      if (wr && !accept && m_drop < 255) m_drop++;
      if (clr_now) begin
         mq_addr.delete(); mq_col.delete();
         m_clear = 1; m_sweep = 0; m_ccol = cc;
      end else if (accept) begin
         mq_addr.push_back(y * 160 + x);
         mq_col.push_back(c);
      end
   endtask

   task automatic idle(input int n, input bit g);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, g);
   endtask

   // Monitor: every RAM write must match the head of the expected queue
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset && mem_we) begin
            if (exp_addr.size() == 0) begin
               chk("unexpected_write_addr", mem_addr, -1);
            end else begin
               chk("write_addr", mem_addr, exp_addr.pop_front());
               chk("write_data", mem_data, exp_col.pop_front());
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "timeout");
   end

   initial begin
      int guard;
      reset = 1'b1;
      pix_wr = 0; pix_x = 0; pix_y = 0; pix_colour = 0;
      clear_req = 0; clear_colour = 0; mem_grant = 0;
      #12;
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pix_ready", pix_ready, 1);
      @(negedge clk);
      reset = 1'b0;

      // Single pixel, grant held high: expect addr 485 colour 6
      cycle(1, 5, 3, 6, 0, 0, 1);
      idle(3, 1);

      // Backpressure: fill with grant low, 5th strobe drops, then drain
      for (int i = 0; i < 5; i++) cycle(1, 10 + i, 7, i + 1, 0, 0, 0);
      idle(6, 1);

      // Bounds
      cycle(1, 160, 0, 2, 0, 0, 1);
      cycle(1, 0, 120, 2, 0, 0, 1);
      cycle(1, 159, 119, 7, 0, 0, 1);
      idle(3, 1);

      // Push with pop at count 4 (push dropped) and at count 2 (count held)
      for (int i = 0; i < 4; i++) cycle(1, i, 1, 1, 0, 0, 0);
      cycle(1, 50, 50, 4, 0, 0, 1);
      idle(5, 1);
      for (int i = 0; i < 2; i++) cycle(1, i, 2, 2, 0, 0, 0);
      cycle(1, 60, 60, 5, 0, 0, 1);
      idle(2, 0);
      idle(4, 1);

      // Randomised traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom % 2, $urandom % 180, $urandom % 140, $urandom % 8,
               0, 0, $urandom % 2);
      idle(6, 1);

      // Clear with 2 pending pixels and 50% grant; a same-cycle strobe drops
      cycle(1, 1, 1, 3, 0, 0, 0);
      cycle(1, 2, 2, 4, 0, 0, 0);
      cycle(1, 3, 3, 5, 1, 6, 1);
      guard = 0;
      while (m_clear && guard < 50000) begin
         cycle(0, 0, 0, 0, 1, 2, guard % 2);
         guard++;
      end
      chk("clear_completed", m_clear, 0);
      idle(3, 1);
      cycle(1, 20, 30, 1, 0, 0, 1);
      idle(3, 1);

      // drop_count saturation
      for (int i = 0; i < 260; i++) cycle(1, 200, 0, 0, 0, 0, 1);
      idle(2, 1);

      // Reset in the middle of a clear sweep
      cycle(0, 0, 0, 0, 1, 4, 1);
      guard = 0;
      while (m_sweep < 1000 && guard < 5000) begin
         cycle(0, 0, 0, 0, 0, 0, 1);
         guard++;
      end
      chk("clear_reached_1000", m_sweep, 1000);
      @(negedge clk);
      pix_wr = 0; clear_req = 0; mem_grant = 1;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_mem_we", mem_we, 0);
      chk("async_rst_mem_addr", mem_addr, 0);
      chk("async_rst_mem_data", mem_data, 0);
      chk("async_rst_drop_count", drop_count, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_pix_ready", pix_ready, 1);
      chk("pending_before_reset", exp_addr.size(), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      cycle(1, 10, 20, 3, 0, 0, 1);
      idle(4, 1);
      chk("scoreboard_drained", exp_addr.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
